avmm_io_hub: RTL and testbench

//  Parametrised Avalon-MM slave replacing the separate slider/key/LEDR/HEX PIOs of the MLP Computer system.

---
 rtl/avmm_io_hub_if.sv | 19 +
 rtl/avmm_io_hub.sv | 195 +++++++++++++++++++
 tb/tb_avmm_io_hub.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avmm_io_hub_if.sv
// Avalon-MM slave bus bundle for avmm_io_hub: word address, read/write strobes and data.
// The master modport drives the bus (Nios data master or testbench) and the slave modport is the hub side.
interface avmm_io_hub_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/avmm_io_hub.sv
// Avalon-MM I/O hub: synchronised/debounced switches and keys, key-press edge capture with maskable IRQ,
// LED and 7-segment outputs. Define IO_HUB_DEBOUNCE_EN to enable the tick-based debouncer.
module avmm_io_hub #(
    parameter int SW_W         = 10,
    parameter int KEY_W        = 2,
    parameter int LED_W        = 10,
    parameter int HEX_DIGITS   = 6,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    avmm_io_hub_if.slave            avs,
    output logic                    irq,
    input  logic [SW_W-1:0]         sw_in,
    input  logic [KEY_W-1:0]        key_in,
    output logic [LED_W-1:0]        ledr_out,
    output logic [7*HEX_DIGITS-1:0] hex_seg
);

    localparam int HEX_W = 4 * HEX_DIGITS;

    typedef enum logic [2:0] {
        A_SW   = 3'd0,
        A_KEY  = 3'd1,
        A_EDGE = 3'd2,
        A_MASK = 3'd3,
        A_LEDR = 3'd4,
        A_HEXV = 3'd5,
        A_HEXB = 3'd6,
        A_NONE = 3'd7
    } addr_e;

    if (SW_W < 1 || SW_W > 32 || KEY_W < 1 || KEY_W > 32 || LED_W < 1 || LED_W > 32 ||
        HEX_DIGITS < 1 || HEX_DIGITS > 8 || DEBOUNCE_CYC < 2) begin : g_bad_params
        $error("avmm_io_hub: parameter out of range");
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [SW_W-1:0]  sw_s1_q, sw_s2_q;
    logic [KEY_W-1:0] key_s1_q, key_s2_q;

    // Key synchronisers reset to the released pad level so no phantom press appears after reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            key_s1_q <= '1;
            key_s2_q <= '1;
        end else begin
            sw_s1_q  <= sw_in;
            sw_s2_q  <= sw_s1_q;
            key_s1_q <= key_in;
            key_s2_q <= key_s1_q;
        end
    end

    logic [SW_W-1:0]  sw_db;
    logic [KEY_W-1:0] key_db;

`ifdef IO_HUB_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYC);

    logic [CNT_W-1:0] tick_cnt_q;
    logic             tick;
    logic [SW_W-1:0]  sw_samp_q, sw_db_q, sw_same;
    logic [KEY_W-1:0] key_samp_q, key_db_q, key_same, key_sync;

    assign tick     = (tick_cnt_q == CNT_W'(DEBOUNCE_CYC - 1));
    assign key_sync = ~key_s2_q;
    assign sw_same  = sw_s2_q ~^ sw_samp_q;
    assign key_same = key_sync ~^ key_samp_q;

    // A bit follows its sample only when two consecutive tick samples agree.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tick_cnt_q <= '0;
            sw_samp_q  <= '0;
            sw_db_q    <= '0;
            key_samp_q <= '0;
            key_db_q   <= '0;
        end else begin
            tick_cnt_q <= tick ? '0 : tick_cnt_q + CNT_W'(1);
            if (tick) begin
                sw_samp_q  <= sw_s2_q;
                key_samp_q <= key_sync;
                sw_db_q    <= (sw_same & sw_s2_q) | (~sw_same & sw_db_q);
                key_db_q   <= (key_same & key_sync) | (~key_same & key_db_q);
            end
        end
    end

    assign sw_db  = sw_db_q;
    assign key_db = key_db_q;
`else
    assign sw_db  = sw_s2_q;
    assign key_db = ~key_s2_q;
`endif

    logic [KEY_W-1:0]        key_prev_q, edge_q, edge_d, mask_q, mask_d, edge_clr, key_rise;
    logic [LED_W-1:0]        ledr_q, ledr_d;
    logic [HEX_W-1:0]        hexv_q, hexv_d;
    logic [HEX_DIGITS-1:0]   hexb_q, hexb_d;
    logic [7*HEX_DIGITS-1:0] seg_q, seg_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    irq_q;
    addr_e                   addr;

    assign addr = addr_e'(avs.avs_address);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        edge_clr = '0;
        mask_d   = mask_q;
        ledr_d   = ledr_q;
        hexv_d   = hexv_q;
        hexb_d   = hexb_q;
        rdata_d  = '0;
        key_rise = key_db & ~key_prev_q;

        if (avs.avs_write) begin
            case (addr)
                A_EDGE:  edge_clr = avs.avs_writedata[KEY_W-1:0];
                A_MASK:  mask_d   = avs.avs_writedata[KEY_W-1:0];
                A_LEDR:  ledr_d   = avs.avs_writedata[LED_W-1:0];
                A_HEXV:  hexv_d   = avs.avs_writedata[HEX_W-1:0];
                A_HEXB:  hexb_d   = avs.avs_writedata[HEX_DIGITS-1:0];
                default: ;
            endcase
        end

        // A press landing in the same cycle as its W1C wins.
        edge_d = (edge_q & ~edge_clr) | key_rise;

        // Segments come from next-state values so the registered digits track a write with one cycle latency.
        for (int i = 0; i < HEX_DIGITS; i++) begin
            seg_d[7*i +: 7] = hexb_d[i] ? 7'h7F : seg7(hexv_d[4*i +: 4]);
        end

        // Read mux uses current register values, so a same-cycle write returns the old contents.
        if (avs.avs_read) begin
            case (addr)
                A_SW:    rdata_d = 32'(sw_db);
                A_KEY:   rdata_d = 32'(key_db);
                A_EDGE:  rdata_d = 32'(edge_q);
                A_MASK:  rdata_d = 32'(mask_q);
                A_LEDR:  rdata_d = 32'(ledr_q);
                A_HEXV:  rdata_d = 32'(hexv_q);
                A_HEXB:  rdata_d = 32'(hexb_q);
                A_NONE:  rdata_d = '0;
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            key_prev_q <= '0;
            edge_q     <= '0;
            mask_q     <= '0;
            ledr_q     <= '0;
            hexv_q     <= '0;
            hexb_q     <= '1;
            seg_q      <= '1;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            key_prev_q <= key_db;
            edge_q     <= edge_d;
            mask_q     <= mask_d;
            ledr_q     <= ledr_d;
            hexv_q     <= hexv_d;
            hexb_q     <= hexb_d;
            seg_q      <= seg_d;
            rdata_q    <= rdata_d;
            irq_q      <= |(edge_q & mask_q);
        end
    end

    assign avs.avs_readdata = rdata_q;
    assign irq              = irq_q;
    assign ledr_out         = ledr_q;
    assign hex_seg          = seg_q;

endmodule

// File: tb/tb_avmm_io_hub.sv
// Randomised scoreboard bench for avmm_io_hub: a register/glyph model predicts every read and output;
// a monitor pops expected read data whenever a read completes.
module tb_avmm_io_hub;
    localparam int SW_W         = 10;
    localparam int KEY_W        = 2;
    localparam int LED_W        = 10;
    localparam int HEX_DIGITS   = 6;
    localparam int DEBOUNCE_CYC = 8;
    localparam int SETTLE       = 2 + 2 * DEBOUNCE_CYC + 4;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [SW_W-1:0]         sw;
    logic [KEY_W-1:0]        key;
    logic                    irq;
    logic [LED_W-1:0]        ledr;
    logic [7*HEX_DIGITS-1:0] hex;

    always #5 clk = ~clk;

    avmm_io_hub_if avs ();

    avmm_io_hub #(
        .SW_W(SW_W), .KEY_W(KEY_W), .LED_W(LED_W),
        .HEX_DIGITS(HEX_DIGITS), .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .avs(avs.slave),
        .irq(irq),
        .sw_in(sw),
        .key_in(key),
        .ledr_out(ledr),
        .hex_seg(hex)
    );

    int n_checks = 0;
    int n_pass   = 0;
    exp_t exp_q[$];

    // Behavioural model of the programmer-visible state.
    logic [SW_W-1:0]         m_sw;
    logic [KEY_W-1:0]        m_key, m_edge, m_mask;
    logic [LED_W-1:0]        m_ledr;
    logic [4*HEX_DIGITS-1:0] m_hexv;
    logic [HEX_DIGITS-1:0]   m_hexb;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_sw);
            3'd1:    return 32'(m_key);
            3'd2:    return 32'(m_edge);
            3'd3:    return 32'(m_mask);
            3'd4:    return 32'(m_ledr);
            3'd5:    return 32'(m_hexv);
            3'd6:    return 32'(m_hexb);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [7*HEX_DIGITS-1:0] model_seg();
        logic [7*HEX_DIGITS-1:0] s;
        for (int i = 0; i < HEX_DIGITS; i++) begin
            logic [3:0] nib;
            nib = m_hexv[4*i +: 4];
            s[7*i +: 7] = m_hexb[i] ? 7'h7F : glyph[nib];
        end
        return s;
    endfunction

    function automatic logic model_irq();
        return |(m_edge & m_mask);
    endfunction

    task automatic model_write(input logic [2:0] a, input logic [31:0] d);
        case (a)
            3'd2:    m_edge = m_edge & ~d[KEY_W-1:0];
            3'd3:    m_mask = d[KEY_W-1:0];
            3'd4:    m_ledr = d[LED_W-1:0];
            3'd5:    m_hexv = d[4*HEX_DIGITS-1:0];
            3'd6:    m_hexb = d[HEX_DIGITS-1:0];
            default: ;
        endcase
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Monitor: every completed read is compared with the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            if (avs.avs_read === 1'b1) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL readdata: got %h with no read expected", avs.avs_readdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("read addr%0d", e.addr), 64'(avs.avs_readdata), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before 2 ms");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_read(input logic [2:0] a);
        avs.avs_address = a;
        avs.avs_read    = 1'b1;
        exp_q.push_back('{addr: a, data: model_read(a)});
        @(negedge clk);
        avs.avs_read = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        avs.avs_address   = a;
        avs.avs_writedata = d;
        avs.avs_write     = 1'b1;
        @(negedge clk);
        avs.avs_write = 1'b0;
        model_write(a, d);
    endtask

    task automatic bus_rw(input logic [2:0] a, input logic [31:0] d);
        avs.avs_address   = a;
        avs.avs_writedata = d;
        avs.avs_write     = 1'b1;
        avs.avs_read      = 1'b1;
        exp_q.push_back('{addr: a, data: model_read(a)});
        @(negedge clk);
        avs.avs_write = 1'b0;
        avs.avs_read  = 1'b0;
        model_write(a, d);
    endtask

    task automatic set_keys(input logic [KEY_W-1:0] pressed);
        logic [KEY_W-1:0] rises;
        rises = pressed & ~m_key;
        key = ~pressed;
        idle(SETTLE);
        m_edge = m_edge | rises;
        m_key  = pressed;
    endtask

    initial begin
        avs.avs_address   = '0;
        avs.avs_read      = 1'b0;
        avs.avs_write     = 1'b0;
        avs.avs_writedata = '0;
        sw  = '0;
        key = '1;
        m_sw = '0; m_key = '0; m_edge = '0; m_mask = '0;
        m_ledr = '0; m_hexv = '0; m_hexb = '1;

        idle(3);
        check("reset hex_seg", 64'(hex), 64'(42'h3FF_FFFF_FFFF));
        check("reset ledr_out", 64'(ledr), 64'd0);
        check("reset irq", 64'(irq), 64'd0);
        rst_n = 1'b1;
        idle(2);
        bus_read(3'd2);
        bus_read(3'd6);
        bus_read(3'd7);

        sw = 10'h2A5;
        idle(40);
        m_sw = sw;
        bus_read(3'd0);

`ifdef IO_HUB_DEBOUNCE_EN
        sw = sw ^ 10'h001;
        idle(3);
        sw = m_sw;
        idle(SETTLE);
        bus_read(3'd0);
`else
        // Pad change at this edge: a read on the 2nd clock still sees the old value, the 3rd sees the new.
        sw = 10'h15A;
        @(negedge clk);
        avs.avs_address = 3'd0;
        avs.avs_read    = 1'b1;
        exp_q.push_back('{addr: 3'd0, data: 32'(m_sw)});
        @(negedge clk);
        exp_q.push_back('{addr: 3'd0, data: 32'h15A});
        @(negedge clk);
        avs.avs_read = 1'b0;
        m_sw = 10'h15A;
`endif

        bus_write(3'd4, 32'hFFFF_FFFF);
        check("ledr all ones", 64'(ledr), 64'h3FF);
        bus_read(3'd4);
        bus_write(3'd0, 32'h0000_0123);
        bus_read(3'd0);

        bus_write(3'd5, 32'h0000_0A50);
        bus_write(3'd6, 32'h0000_003C);
        check("hex digits", 64'(hex), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40}));
        bus_read(3'd5);

        bus_write(3'd3, 32'd1);
        set_keys(2'b01);
        check("irq after press", 64'(irq), 64'd1);
        bus_read(3'd2);
        bus_write(3'd2, 32'd1);
        idle(1);
        check("irq after w1c", 64'(irq), 64'd0);
        set_keys(2'b00);
        bus_read(3'd2);
        check("irq after release", 64'(irq), 64'd0);

        set_keys(2'b01);
        set_keys(2'b00);
        check("irq held edge", 64'(irq), 64'd1);
`ifndef IO_HUB_DEBOUNCE_EN
        // Debounced press lands 2 clocks after the pad; the edge bit registers on the 3rd clock,
        // which is exactly when this W1C is sampled.
        key = 2'b10;
        idle(2);
        bus_write(3'd2, 32'd1);
        m_edge = m_edge | 2'b01;
        m_key  = 2'b01;
        check("irq w1c vs press", 64'(irq), 64'd1);
        idle(1);
        check("irq w1c vs press+1", 64'(irq), 64'd1);
        bus_read(3'd2);
        set_keys(2'b00);
`endif
        bus_write(3'd2, 32'd3);
        idle(2);

        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0: begin
                    bus_write(3'd4, $urandom);
                    check("rand ledr", 64'(ledr), 64'(m_ledr));
                end
                1: begin
                    bus_write(3'd5, $urandom);
                    check("rand hex val", 64'(hex), 64'(model_seg()));
                end
                2: begin
                    bus_write(3'd6, $urandom);
                    check("rand hex blank", 64'(hex), 64'(model_seg()));
                end
                3: begin
                    bus_write(3'd3, $urandom);
                    idle(1);
                    check("rand irq mask", 64'(irq), 64'(model_irq()));
                end
                4: begin
                    sw = SW_W'($urandom);
                    idle(SETTLE);
                    m_sw = sw;
                    bus_read(3'd0);
                end
                5: bus_read(3'($urandom_range(0, 7)));
                6: bus_rw(3'($urandom_range(3, 6)), $urandom);
                7: begin
                    set_keys(KEY_W'($urandom));
                    check("rand irq keys", 64'(irq), 64'(model_irq()));
                    bus_read(3'd1);
                end
                8: begin
                    bus_write(3'd2, $urandom);
                    idle(1);
                    check("rand irq w1c", 64'(irq), 64'(model_irq()));
                end
                default: bus_read(3'd2);
            endcase
        end

        idle(3);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
